// File: rtl/sram_1rw1r_arbiter.sv
// Purpose: sequencer for the 32x256 1RW1R cache SRAM; arbitrates REQ0/REQ1 onto RW port 0, drives RD onto read port 1.
// Latency: every accepted request (read or write, either port) returns exactly one response pulse 2 cycles after acceptance.
// Backpressure: port 0 never stalls; rd_ready drops only when port 0 writes the same address that cycle. Option: SRAM_ARB_FIXED_PRIO_EN.
module sram_1rw1r_arbiter #(
  parameter int NUM_WMASKS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [NUM_WMASKS-1:0] req0_wmask,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  // requester 1
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [NUM_WMASKS-1:0] req1_wmask,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  // read-only client on port 1
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  // SRAM macro port 0 (RW)
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  // SRAM macro port 1 (R)
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  // Selected port-0 command, carried as one bundle through the mux.
  typedef struct packed {
    logic                  we;
    logic [NUM_WMASKS-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } p0_cmd_t;

  // First response stage: what was issued last cycle while the macro performs the access.
  typedef struct packed {
    logic vld;
    logic owner;   // 0 = REQ0, 1 = REQ1
    logic is_rd;
  } s1_meta_t;

  logic            gnt0;
  logic            gnt1;
  logic            issue0;
  logic            wr_active;
  logic            wr_hit;
  logic            rd_accept;
  p0_cmd_t         p0_cmd;

  s1_meta_t        s1_q;
  logic            s2_vld_q;
  logic            s2_owner_q;
  logic [DATA_WIDTH-1:0] s2_dat_q;

  logic            rd_s1_vld_q;
  logic            rd_s2_vld_q;
  logic [DATA_WIDTH-1:0] rd_s2_dat_q;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Grant: REQ0 always wins; REQ1 only gets the port when REQ0 is idle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = req0_valid;
      gnt1 = req1_valid & ~req0_valid;
    end
  end
`else
  // Last-grant pointer: 1 means REQ1 was served last, so REQ0 wins the next tie.
  logic last_gnt_q;

  // Grant: a lone requester always wins; on a tie serve the one opposite the last grant.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = req0_valid & (~req1_valid | last_gnt_q);
      gnt1 = req1_valid & (~req0_valid | ~last_gnt_q);
    end
  end

  // Pointer moves only when a grant is actually issued; reset favours REQ0 on the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
    end else if (issue0) begin
      last_gnt_q <= gnt1;
    end
  end
`endif

  assign issue0     = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Port-0 command mux: steer the granted requester's fields toward the macro.
  always_comb begin
    p0_cmd = '0;
    if (gnt1) begin
      p0_cmd.we    = req1_we;
      p0_cmd.wmask = req1_wmask;
      p0_cmd.addr  = req1_addr;
      p0_cmd.wdata = req1_wdata;
    end else begin
      p0_cmd.we    = req0_we;
      p0_cmd.wmask = req0_wmask;
      p0_cmd.addr  = req0_addr;
      p0_cmd.wdata = req0_wdata;
    end
  end

  assign wr_active = issue0 & p0_cmd.we;

  // Macro port 0 pins: driven in the grant cycle so the macro registers them at the closing edge.
  always_comb begin
    sram_csb0   = ~issue0;
    sram_web0   = ~wr_active;
    sram_wmask0 = wr_active ? p0_cmd.wmask : '0;
    sram_addr0  = issue0    ? p0_cmd.addr  : '0;
    sram_din0   = wr_active ? p0_cmd.wdata : '0;
  end

  // A masked-off write changes nothing, so it cannot race with a port-1 read of the same word.
  assign wr_hit    = wr_active & (|p0_cmd.wmask) & rd_valid & (rd_addr == p0_cmd.addr);
  assign rd_ready  = ~rst & ~wr_hit;
  assign rd_accept = rd_valid & rd_ready;

  // Macro port 1 pins: chip select only for an accepted read.
  always_comb begin
    sram_csb1  = ~rd_accept;
    sram_addr1 = rd_accept ? rd_addr : '0;
  end

  // Port-0 response pipeline: S1 tracks the access, S2 captures read data after the macro's negedge access.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_vld_q   <= 1'b0;
      s2_owner_q <= 1'b0;
      s2_dat_q   <= '0;
    end else begin
      s1_q.vld   <= issue0;
      s1_q.owner <= gnt1;
      s1_q.is_rd <= issue0 & ~p0_cmd.we;
      s2_vld_q   <= s1_q.vld;
      s2_owner_q <= s1_q.owner;
      s2_dat_q   <= (s1_q.vld & s1_q.is_rd) ? sram_dout0 : '0;
    end
  end

  // Port-1 response pipeline: same two-stage shape, always a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_s1_vld_q <= 1'b0;
      rd_s2_vld_q <= 1'b0;
      rd_s2_dat_q <= '0;
    end else begin
      rd_s1_vld_q <= rd_accept;
      rd_s2_vld_q <= rd_s1_vld_q;
      rd_s2_dat_q <= rd_s1_vld_q ? sram_dout1 : '0;
    end
  end

  // Response outputs: masked during reset so in-flight work never surfaces; data routed to its owner only.
  always_comb begin
    rsp0_valid   = ~rst & s2_vld_q & ~s2_owner_q;
    rsp1_valid   = ~rst & s2_vld_q &  s2_owner_q;
    rsp0_rdata   = s2_owner_q ? '0 : s2_dat_q;
    rsp1_rdata   = s2_owner_q ? s2_dat_q : '0;
    rd_rsp_valid = ~rst & rd_s2_vld_q;
    rd_rsp_data  = rd_s2_dat_q;
  end

endmodule

// File: tb/tb_sram_1rw1r_arbiter.sv
// Directed, table-driven bench for sram_1rw1r_arbiter with a behavioural 1RW1R macro model.
// Each vector is one clock cycle: inputs applied after the posedge, outputs checked after the negedge.
// Expectations are hand-computed; a few extra sequences cover reset mid-flight and priority behaviour.
module tb_sram_1rw1r_arbiter;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [3:0]  req0_wmask;
  logic [7:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [3:0]  req1_wmask;
  logic [7:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        rd_valid, rd_ready;
  logic [7:0]  rd_addr;
  logic        rd_rsp_valid;
  logic [31:0] rd_rsp_data;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0, sram_dout0;
  logic        sram_csb1;
  logic [7:0]  sram_addr1;
  logic [31:0] sram_dout1;

  int checks = 0;
  int errors = 0;

  sram_1rw1r_arbiter #(.NUM_WMASKS(4), .DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_wmask(req0_wmask), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_wmask(req1_wmask), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural macro: inputs registered at posedge, access performed at the following negedge.
  logic [31:0] mem [256];
  logic        m_csb0, m_web0, m_csb1;
  logic [3:0]  m_wmask0;
  logic [7:0]  m_addr0, m_addr1;
  logic [31:0] m_din0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    sram_dout0 = 32'h0;
    sram_dout1 = 32'h0;
    m_csb0 = 1'b1; m_web0 = 1'b1; m_csb1 = 1'b1;
    m_wmask0 = 4'h0; m_addr0 = 8'h0; m_addr1 = 8'h0; m_din0 = 32'h0;
  end

  always @(posedge clk) begin
    m_csb0   <= sram_csb0;
    m_web0   <= sram_web0;
    m_wmask0 <= sram_wmask0;
    m_addr0  <= sram_addr0;
    m_din0   <= sram_din0;
    m_csb1   <= sram_csb1;
    m_addr1  <= sram_addr1;
  end

  always @(negedge clk) begin
    if (!m_csb0) begin
      if (!m_web0) begin
        for (int b = 0; b < 4; b++)
          if (m_wmask0[b]) mem[m_addr0][b*8 +: 8] = m_din0[b*8 +: 8];
      end else begin
        sram_dout0 = mem[m_addr0];
      end
    end
    if (!m_csb1) sram_dout1 = mem[m_addr1];
  end

  typedef struct {
    bit          rst;
    bit          v0, we0;
    logic [3:0]  m0;
    logic [7:0]  a0;
    logic [31:0] d0;
    bit          v1, we1;
    logic [3:0]  m1;
    logic [7:0]  a1;
    logic [31:0] d1;
    bit          rv;
    logic [7:0]  ra;
    bit          r0, r1, rr;      // expected req0_ready, req1_ready, rd_ready
    bit          s0, s1, sr;      // expected rsp0_valid, rsp1_valid, rd_rsp_valid
    logic [31:0] x0, x1, xr;      // expected data when the matching response is valid
  } vec_t;

  function automatic vec_t mk(bit rst, bit v0, bit we0, logic [3:0] m0, logic [7:0] a0, logic [31:0] d0,
                              bit v1, bit we1, logic [3:0] m1, logic [7:0] a1, logic [31:0] d1,
                              bit rv, logic [7:0] ra, bit r0, bit r1, bit rr, bit s0, bit s1, bit sr,
                              logic [31:0] x0, logic [31:0] x1, logic [31:0] xr);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.we0 = we0; v.m0 = m0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.m1 = m1; v.a1 = a1; v.d1 = d1;
    v.rv = rv; v.ra = ra; v.r0 = r0; v.r1 = r1; v.rr = rr;
    v.s0 = s0; v.s1 = s1; v.sr = sr; v.x0 = x0; v.x1 = x1; v.xr = xr;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst;
    req0_valid = v.v0; req0_we = v.we0; req0_wmask = v.m0; req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_we = v.we1; req1_wmask = v.m1; req1_addr = v.a1; req1_wdata = v.d1;
    rd_valid = v.rv; rd_addr = v.ra;
  endtask

  task automatic step(input vec_t v);
    @(posedge clk); #1;
    apply(v);
    @(negedge clk); #1;
  endtask

  // Compares every DUT output of the current cycle against the vector; macro-pin expectations derive from the expected grants.
  task automatic check_row(input int idx, input vec_t v);
    bit          g0, g1, wr;
    logic [3:0]  em;
    g0 = v.r0 & v.v0;
    g1 = v.r1 & v.v1;
    wr = (g0 & v.we0) | (g1 & v.we1);
    em = (g0 & v.we0) ? v.m0 : ((g1 & v.we1) ? v.m1 : 4'h0);
    chk("req0_ready", idx, req0_ready, v.r0);
    chk("req1_ready", idx, req1_ready, v.r1);
    chk("rd_ready", idx, rd_ready, v.rr);
    chk("sram_csb0", idx, sram_csb0, !(g0 | g1));
    chk("sram_web0", idx, sram_web0, !wr);
    chk("sram_wmask0", idx, sram_wmask0, em);
    if (g0 | g1) chk("sram_addr0", idx, sram_addr0, g0 ? v.a0 : v.a1);
    if (wr) chk("sram_din0", idx, sram_din0, g0 ? v.d0 : v.d1);
    chk("sram_csb1", idx, sram_csb1, !(v.rv & v.rr));
    if (v.rv & v.rr) chk("sram_addr1", idx, sram_addr1, v.ra);
    chk("rsp0_valid", idx, rsp0_valid, v.s0);
    chk("rsp1_valid", idx, rsp1_valid, v.s1);
    chk("rd_rsp_valid", idx, rd_rsp_valid, v.sr);
    if (v.s0) chk("rsp0_rdata", idx, rsp0_rdata, v.x0);
    if (v.s1) chk("rsp1_rdata", idx, rsp1_rdata, v.x1);
    if (v.sr) chk("rd_rsp_data", idx, rd_rsp_data, v.xr);
  endtask

  localparam int NV = 24;
  vec_t vt[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    // rst  v0 we0 m0 a0 d0                 v1 we1 m1 a1 d1          rv ra      r0 r1 rr  s0 s1 sr  x0 x1 xr
    vt[0]  = mk(1, 0,0,4'h0,8'h00,32'h0,        0,0,4'h0,8'h00,32'h0,    0,8'h00,  0,0,0, 0,0,0, 32'h0,32'h0,32'h0);
    // write 0x10, then REQ1 reads it back
    vt[1]  = mk(0, 1,1,4'hF,8'h10,32'hDEADBEEF, 0,0,4'h0,8'h00,32'h0,    0,8'h00,  1,0,1, 0,0,0, 32'h0,32'h0,32'h0);
    vt[2]  = mk(0, 0,0,4'h0,8'h00,32'h0,        1,0,4'h0,8'h10,32'h0,    0,8'h00,  0,1,1, 0,0,0, 32'h0,32'h0,32'h0);
    // full write then partial write of 0x20, then REQ1 reads the merged word
    vt[3]  = mk(0, 1,1,4'hF,8'h20,32'h11223344, 0,0,4'h0,8'h00,32'h0,    0,8'h00,  1,0,1, 1,0,0, 32'h0,32'h0,32'h0);
    vt[4]  = mk(0, 1,1,4'h5,8'h20,32'hAABBCCDD, 0,0,4'h0,8'h00,32'h0,    0,8'h00,  1,0,1, 0,1,0, 32'h0,32'hDEADBEEF,32'h0);
    vt[5]  = mk(0, 0,0,4'h0,8'h00,32'h0,        1,0,4'h0,8'h20,32'h0,    0,8'h00,  0,1,1, 1,0,0, 32'h0,32'h0,32'h0);
    vt[6]  = mk(0, 0,0,4'h0,8'h00,32'h0,        0,0,4'h0,8'h00,32'h0,    0,8'h00,  0,0,1, 1,0,0, 32'h0,32'h0,32'h0);
    vt[7]  = mk(0, 0,0,4'h0,8'h00,32'h0,        0,0,4'h0,8'h00,32'h0,    0,8'h00,  0,0,1, 0,1,0, 32'h0,32'h11BB33DD,32'h0);
    // reset with all requesters active: nothing may be accepted
    vt[8]  = mk(1, 1,0,4'h0,8'h10,32'h0,        1,0,4'h0,8'h20,32'h0,    1,8'h10,  0,0,0, 0,0,0, 32'h0,32'h0,32'h0);
    // contention: both hold reads for 4 cycles
    vt[9]  = mk(0, 1,0,4'h0,8'h10,32'h0,        1,0,4'h0,8'h20,32'h0,    0,8'h00,  1,0,1, 0,0,0, 32'h0,32'h0,32'h0);
    vt[10] = mk(0, 1,0,4'h0,8'h10,32'h0,        1,0,4'h0,8'h20,32'h0,    0,8'h00,  FIXED,!FIXED,1, 0,0,0, 32'h0,32'h0,32'h0);
    vt[11] = mk(0, 1,0,4'h0,8'h10,32'h0,        1,0,4'h0,8'h20,32'h0,    0,8'h00,  1,0,1, 1,0,0, 32'hDEADBEEF,32'h0,32'h0);
    vt[12] = mk(0, 1,0,4'h0,8'h10,32'h0,        1,0,4'h0,8'h20,32'h0,    0,8'h00,  FIXED,!FIXED,1, FIXED,!FIXED,0, 32'hDEADBEEF,32'h11BB33DD,32'h0);
    vt[13] = mk(0, 0,0,4'h0,8'h00,32'h0,        0,0,4'h0,8'h00,32'h0,    0,8'h00,  0,0,1, 1,0,0, 32'hDEADBEEF,32'h0,32'h0);
    vt[14] = mk(0, 0,0,4'h0,8'h00,32'h0,        0,0,4'h0,8'h00,32'h0,    0,8'h00,  0,0,1, FIXED,!FIXED,0, 32'hDEADBEEF,32'h11BB33DD,32'h0);
    // collision on 0x30, retry next cycle; then different-address read alongside a write
    vt[15] = mk(0, 1,1,4'hF,8'h30,32'h5A5A5A5A, 0,0,4'h0,8'h00,32'h0,    1,8'h30,  1,0,0, 0,0,0, 32'h0,32'h0,32'h0);
    vt[16] = mk(0, 0,0,4'h0,8'h00,32'h0,        0,0,4'h0,8'h00,32'h0,    1,8'h30,  0,0,1, 0,0,0, 32'h0,32'h0,32'h0);
    vt[17] = mk(0, 1,1,4'hF,8'h40,32'h01020304, 0,0,4'h0,8'h00,32'h0,    1,8'h10,  1,0,1, 1,0,0, 32'h0,32'h0,32'h0);
    vt[18] = mk(0, 0,0,4'h0,8'h00,32'h0,        0,0,4'h0,8'h00,32'h0,    0,8'h00,  0,0,1, 0,0,1, 32'h0,32'h0,32'h5A5A5A5A);
    vt[19] = mk(0, 0,0,4'h0,8'h00,32'h0,        0,0,4'h0,8'h00,32'h0,    0,8'h00,  0,0,1, 1,0,1, 32'h0,32'h0,32'hDEADBEEF);
    // zero-mask write: issued and acknowledged, memory unchanged, no collision stall
    vt[20] = mk(0, 0,0,4'h0,8'h00,32'h0,        1,1,4'h0,8'h10,32'hFFFFFFFF, 1,8'h10, 0,1,1, 0,0,0, 32'h0,32'h0,32'h0);
    vt[21] = mk(0, 1,0,4'h0,8'h10,32'h0,        0,0,4'h0,8'h00,32'h0,    0,8'h00,  1,0,1, 0,0,0, 32'h0,32'h0,32'h0);
    vt[22] = mk(0, 0,0,4'h0,8'h00,32'h0,        0,0,4'h0,8'h00,32'h0,    0,8'h00,  0,0,1, 0,1,1, 32'h0,32'h0,32'hDEADBEEF);
    vt[23] = mk(0, 0,0,4'h0,8'h00,32'h0,        0,0,4'h0,8'h00,32'h0,    0,8'h00,  0,0,1, 1,0,0, 32'hDEADBEEF,32'h0,32'h0);

    apply(vt[0]);
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      step(vt[i]);
      check_row(i, vt[i]);
    end

    // Reset mid-flight: REQ1 then REQ0 reads issue, reset lands while both are in the pipeline.
    step(mk(0, 0,0,4'h0,8'h00,32'h0, 1,0,4'h0,8'h20,32'h0, 0,8'h00, 0,1,1, 0,0,0, 32'h0,32'h0,32'h0));
    check_row(100, mk(0, 0,0,4'h0,8'h00,32'h0, 1,0,4'h0,8'h20,32'h0, 0,8'h00, 0,1,1, 0,0,0, 32'h0,32'h0,32'h0));
    step(mk(0, 1,0,4'h0,8'h10,32'h0, 0,0,4'h0,8'h00,32'h0, 0,8'h00, 1,0,1, 0,0,0, 32'h0,32'h0,32'h0));
    check_row(101, mk(0, 1,0,4'h0,8'h10,32'h0, 0,0,4'h0,8'h00,32'h0, 0,8'h00, 1,0,1, 0,0,0, 32'h0,32'h0,32'h0));
    for (int k = 0; k < 2; k++) begin
      step(mk(1, 1,1,4'hF,8'h10,32'h0, 1,0,4'h0,8'h20,32'h0, 1,8'h30, 0,0,0, 0,0,0, 32'h0,32'h0,32'h0));
      chk("csb0_in_reset", 102 + k, sram_csb0, 1'b1);
      chk("csb1_in_reset", 102 + k, sram_csb1, 1'b1);
      chk("web0_in_reset", 102 + k, sram_web0, 1'b1);
      chk("rsp_any_in_reset", 102 + k, {rsp0_valid, rsp1_valid, rd_rsp_valid}, 3'b000);
    end
    // first post-reset tie goes to REQ0; dropped requests never respond
    step(mk(0, 1,0,4'h0,8'h10,32'h0, 1,0,4'h0,8'h20,32'h0, 0,8'h00, 1,0,1, 0,0,0, 32'h0,32'h0,32'h0));
    check_row(104, mk(0, 1,0,4'h0,8'h10,32'h0, 1,0,4'h0,8'h20,32'h0, 0,8'h00, 1,0,1, 0,0,0, 32'h0,32'h0,32'h0));
    step(mk(0, 0,0,4'h0,8'h00,32'h0, 0,0,4'h0,8'h00,32'h0, 0,8'h00, 0,0,1, 0,0,0, 32'h0,32'h0,32'h0));
    check_row(105, mk(0, 0,0,4'h0,8'h00,32'h0, 0,0,4'h0,8'h00,32'h0, 0,8'h00, 0,0,1, 0,0,0, 32'h0,32'h0,32'h0));
    step(mk(0, 0,0,4'h0,8'h00,32'h0, 0,0,4'h0,8'h00,32'h0, 0,8'h00, 0,0,1, 1,0,0, 32'hDEADBEEF,32'h0,32'h0));
    check_row(106, mk(0, 0,0,4'h0,8'h00,32'h0, 0,0,4'h0,8'h00,32'h0, 0,8'h00, 0,0,1, 1,0,0, 32'hDEADBEEF,32'h0,32'h0));

    // Three-cycle tie after a fresh reset: alternates under round-robin, REQ0 every cycle under fixed priority.
    step(mk(1, 0,0,4'h0,8'h00,32'h0, 0,0,4'h0,8'h00,32'h0, 0,8'h00, 0,0,0, 0,0,0, 32'h0,32'h0,32'h0));
    check_row(107, mk(1, 0,0,4'h0,8'h00,32'h0, 0,0,4'h0,8'h00,32'h0, 0,8'h00, 0,0,0, 0,0,0, 32'h0,32'h0,32'h0));
    for (int k = 0; k < 3; k++) begin
      bit e0;
      e0 = (k != 1) | FIXED;
      step(mk(0, 1,0,4'h0,8'h10,32'h0, 1,0,4'h0,8'h20,32'h0, 0,8'h00, e0,!e0,1, (k == 2),0,0, 32'hDEADBEEF,32'h0,32'h0));
      check_row(108 + k, mk(0, 1,0,4'h0,8'h10,32'h0, 1,0,4'h0,8'h20,32'h0, 0,8'h00, e0,!e0,1, (k == 2),0,0, 32'hDEADBEEF,32'h0,32'h0));
    end
    step(mk(0, 0,0,4'h0,8'h00,32'h0, 0,0,4'h0,8'h00,32'h0, 0,8'h00, 0,0,1, FIXED,!FIXED,0, 32'hDEADBEEF,32'h11BB33DD,32'h0));
    check_row(111, mk(0, 0,0,4'h0,8'h00,32'h0, 0,0,4'h0,8'h00,32'h0, 0,8'h00, 0,0,1, FIXED,!FIXED,0, 32'hDEADBEEF,32'h11BB33DD,32'h0));
    step(mk(0, 0,0,4'h0,8'h00,32'h0, 0,0,4'h0,8'h00,32'h0, 0,8'h00, 0,0,1, 1,0,0, 32'hDEADBEEF,32'h0,32'h0));
    check_row(112, mk(0, 0,0,4'h0,8'h00,32'h0, 0,0,4'h0,8'h00,32'h0, 0,8'h00, 0,0,1, 1,0,0, 32'hDEADBEEF,32'h0,32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
